// File: rtl/bs_pkg.sv
// Shared widths, limits and error-cause encoding for the bitstream window buffer.
package bs_pkg;

    localparam int WORD_W  = 16;
    localparam int BUF_W   = 48;
    localparam int LVL_W   = 6;
    localparam int MAX_ADV = 16;
    localparam int SHAMT_W = 5;

    typedef enum logic [2:0] {
        ERR_NONE,
        ADV_EMPTY,
        ADV_RANGE,
        ALIGN_SHORT,
        ADV_ALIGN_COLLIDE
    } err_cause_e;

    // Bits still to skip before the stream reaches the next byte boundary.
    function automatic logic [2:0] align_skip(input logic [2:0] pos_lsb);
        return 3'd0 - pos_lsb;
    endfunction

endpackage

// File: rtl/bs_lshift48.sv
// Combinational logarithmic left shifter for the bit buffer; shift amount 0..16.
module bs_lshift48
    import bs_pkg::*;
#(
    parameter int WIDTH = BUF_W
) (
    input  logic [WIDTH-1:0]   data_i,
    input  logic [SHAMT_W-1:0] shamt_i,
    output logic [WIDTH-1:0]   data_o
);

    logic [WIDTH-1:0] stage;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        stage = data_i;
        for (int s = 0; s < SHAMT_W; s++) begin
            if (shamt_i[s]) begin
                stage = stage << (1 << s);
            end
        end
        data_o = stage;
    end

endmodule

// File: rtl/bs_window_buffer.sv
// Bitstream window buffer: accepts 16-bit words, exposes the next 16 unconsumed
// bits MSB-aligned, and consumes 1..16 bits or skips to a byte boundary on request.
module bs_window_buffer #(
    parameter int WORD_W = bs_pkg::WORD_W,
    parameter int BUF_W  = bs_pkg::BUF_W
) (
    input  logic                     wb_clk_i,
    input  logic                     wb_rst_i,
    input  logic [WORD_W-1:0]        in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [WORD_W-1:0]        win_data,
    output logic                     win_valid,
    input  logic                     adv_valid,
    input  logic [4:0]               adv_len,
    input  logic                     align_req,
    output logic [bs_pkg::LVL_W-1:0] bit_level,
    output logic [31:0]              bit_pos,
    output logic                     err
);

    import bs_pkg::*;

    logic [BUF_W-1:0]   buf_q, buf_d;
    logic [BUF_W-1:0]   shifted;
    logic [BUF_W-1:0]   push_word;
    logic [LVL_W-1:0]   level_q, level_d, level_rem;
    logic [31:0]        pos_q, pos_d;
    logic               err_q, err_d;
    logic               push;
    logic [SHAMT_W-1:0] shamt;
    logic [2:0]         align_k;
    err_cause_e         cause;

    assign in_ready  = (level_q <= LVL_W'(BUF_W - WORD_W));
    assign win_valid = (level_q >= LVL_W'(WORD_W));
    assign push      = in_valid && in_ready;
    assign align_k   = align_skip(pos_q[2:0]);

    // Decide how many bits leave the buffer this cycle and whether the request was illegal.
    always_comb begin
        shamt = '0;
        cause = ERR_NONE;
        if (adv_valid) begin
            if (align_req) begin
                cause = ADV_ALIGN_COLLIDE;
            end
            if (adv_len != 5'd0) begin
                if (adv_len > 5'(MAX_ADV)) begin
                    cause = ADV_RANGE;
                end else if (!win_valid) begin
                    cause = ADV_EMPTY;
                end else begin
                    shamt = adv_len;
                end
            end
        end else if (align_req && (align_k != 3'd0)) begin
            if (level_q >= LVL_W'(align_k)) begin
                shamt = SHAMT_W'(align_k);
            end else begin
                cause = ALIGN_SHORT;
            end
        end
    end

    bs_lshift48 #(
        .WIDTH(BUF_W)
    ) u_shift (
        .data_i (buf_q),
        .shamt_i(shamt),
        .data_o (shifted)
    );

    // Bits past the level stay zero, so a new word can simply be OR-ed in after the remainder.
    always_comb begin
        level_rem = level_q - LVL_W'(shamt);
        push_word = '0;
        if (push) begin
            push_word = {in_data, {(BUF_W - WORD_W){1'b0}}} >> level_rem;
        end
        buf_d   = shifted | push_word;
        level_d = level_rem + (push ? LVL_W'(WORD_W) : '0);
        pos_d   = pos_q + 32'(shamt);
        err_d   = err_q || (cause != ERR_NONE);
    end

    always_ff @(posedge wb_clk_i) begin
        // NOTE: sequential state is updated only with non-blocking assignments.
        if (wb_rst_i) begin
            buf_q   <= '0;
            level_q <= '0;
            pos_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            buf_q   <= buf_d;
            level_q <= level_d;
            pos_q   <= pos_d;
            err_q   <= err_d;
        end
    end

    assign win_data  = buf_q[BUF_W-1 -: WORD_W];
    assign bit_level = level_q;
    assign bit_pos   = pos_q;
    assign err       = err_q;

endmodule

// File: tb/tb_bs_window_buffer.sv
// Scoreboard bench for bs_window_buffer: a bit-queue reference model predicts each
// post-edge state, and a monitor compares it with the DUT after every rising edge.
module tb_bs_window_buffer;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i;
    logic [15:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] win_data;
    logic        win_valid;
    logic        adv_valid;
    logic [4:0]  adv_len;
    logic        align_req;
    logic [5:0]  bit_level;
    logic [31:0] bit_pos;
    logic        err;

    always #5 wb_clk_i = ~wb_clk_i;

    bs_window_buffer dut (
        .wb_clk_i (wb_clk_i),
        .wb_rst_i (wb_rst_i),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .win_data (win_data),
        .win_valid(win_valid),
        .adv_valid(adv_valid),
        .adv_len  (adv_len),
        .align_req(align_req),
        .bit_level(bit_level),
        .bit_pos  (bit_pos),
        .err      (err)
    );

    typedef struct packed {
        logic [15:0] win;
        logic        wv;
        logic        rdy;
        logic [5:0]  lvl;
        logic [31:0] pos;
        logic        err;
    } snap_t;

    int    n_tests = 0;
    int    n_fail  = 0;
    snap_t exp_q[$];
    snap_t mon_exp;

    // Reference model: the unconsumed stream as a plain queue of bits, oldest first.
    bit          m_bits[$];
    logic [31:0] m_pos = '0;
    logic        m_err = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void model_step(input logic rst, input logic iv, input logic [15:0] d,
                                       input logic av, input logic [4:0] len, input logic al);
        int level;
        int n;
        int k;
        if (rst) begin
            m_bits.delete();
            m_pos = '0;
            m_err = 1'b0;
            return;
        end
        level = m_bits.size();
        n = 0;
        if (av) begin
            if (al) m_err = 1'b1;
            if (len != 0) begin
                if (len > 16 || level < 16) m_err = 1'b1;
                else n = int'(len);
            end
        end else if (al) begin
            k = (8 - int'(m_pos % 8)) % 8;
            if (k != 0) begin
                if (level >= k) n = k;
                else m_err = 1'b1;
            end
        end
        for (int i = 0; i < n; i++) void'(m_bits.pop_front());
        m_pos = m_pos + 32'(n);
        if (iv && level <= 32) begin
            for (int i = 15; i >= 0; i--) m_bits.push_back(d[i]);
        end
    endfunction

    function automatic snap_t model_snap();
        snap_t s;
        s.win = '0;
        for (int i = 0; i < 16; i++) begin
            if (i < m_bits.size()) s.win[15-i] = m_bits[i];
        end
        s.lvl = 6'(m_bits.size());
        s.wv  = (m_bits.size() >= 16);
        s.rdy = (m_bits.size() <= 32);
        s.pos = m_pos;
        s.err = m_err;
        return s;
    endfunction

    task automatic cycle(input logic rst, input logic iv, input logic [15:0] d,
                         input logic av, input logic [4:0] len, input logic al);
        wb_rst_i  = rst;
        in_valid  = iv;
        in_data   = d;
        adv_valid = av;
        adv_len   = len;
        align_req = al;
        model_step(rst, iv, d, av, len, al);
        exp_q.push_back(model_snap());
        @(negedge wb_clk_i);
    endtask

    // Monitor: every rising edge yields one registered state to compare.
    always begin
        @(posedge wb_clk_i);
        #1;
        if (exp_q.size() != 0) begin
            mon_exp = exp_q.pop_front();
            check("sb_win_data",  32'(win_data),  32'(mon_exp.win));
            check("sb_win_valid", 32'(win_valid), 32'(mon_exp.wv));
            check("sb_in_ready",  32'(in_ready),  32'(mon_exp.rdy));
            check("sb_bit_level", 32'(bit_level), 32'(mon_exp.lvl));
            check("sb_bit_pos",   bit_pos,        mon_exp.pos);
            check("sb_err",       32'(err),       32'(mon_exp.err));
        end
    end

    logic        r_rst, r_iv, r_av, r_al;
    logic [15:0] r_d;
    logic [4:0]  r_len;

    initial begin
        wb_rst_i = 1'b1; in_valid = 1'b0; in_data = '0;
        adv_valid = 1'b0; adv_len = '0; align_req = 1'b0;

        // Reset state
        cycle(1, 0, 16'h0, 0, 0, 0);
        cycle(1, 0, 16'h0, 0, 0, 0);
        check("rst_level", 32'(bit_level), 32'd0);
        check("rst_ready", 32'(in_ready),  32'd1);
        check("rst_wvalid", 32'(win_valid), 32'd0);
        check("rst_err",   32'(err),       32'd0);
        check("rst_pos",   bit_pos,        32'd0);

        // Two pushes, advance 4, align, push+advance
        cycle(0, 1, 16'hA5F0, 0, 0, 0);
        cycle(0, 1, 16'h1234, 0, 0, 0);
        check("push2_win", 32'(win_data), 32'h0000_A5F0);
        check("push2_level", 32'(bit_level), 32'd32);
        check("push2_wvalid", 32'(win_valid), 32'd1);
        cycle(0, 0, 16'h0, 1, 5'd4, 0);
        check("adv4_win", 32'(win_data), 32'h0000_5F01);
        check("adv4_level", 32'(bit_level), 32'd28);
        check("adv4_pos", bit_pos, 32'd4);
        cycle(0, 0, 16'h0, 0, 0, 1);
        check("align_win", 32'(win_data), 32'h0000_F012);
        check("align_pos", bit_pos, 32'd8);
        check("align_level", 32'(bit_level), 32'd24);
        cycle(0, 1, 16'h5678, 1, 5'd8, 0);
        check("pa8_level", 32'(bit_level), 32'd32);
        cycle(0, 1, 16'hBEEF, 1, 5'd16, 0);
        check("pa16_level", 32'(bit_level), 32'd32);
        check("pa16_win", 32'(win_data), 32'h0000_5678);
        cycle(0, 0, 16'h0, 1, 5'd16, 0);
        check("pa16_next", 32'(win_data), 32'h0000_BEEF);
        check("pa16_pos", bit_pos, 32'd48);
        cycle(0, 0, 16'h0, 0, 0, 1);
        check("align_noop_pos", bit_pos, 32'd48);

        // Advance with fewer than 16 bits held
        cycle(1, 0, 16'h0, 0, 0, 0);
        cycle(0, 1, 16'hC3A5, 0, 0, 0);
        cycle(0, 0, 16'h0, 1, 5'd8, 0);
        check("short_level", 32'(bit_level), 32'd8);
        cycle(0, 0, 16'h0, 1, 5'd3, 0);
        check("short_err", 32'(err), 32'd1);
        check("short_level_kept", 32'(bit_level), 32'd8);
        check("short_pos_kept", bit_pos, 32'd8);
        cycle(0, 1, 16'h1111, 0, 0, 0);
        check("short_err_sticky", 32'(err), 32'd1);
        check("short_after_win", 32'(win_data), 32'h0000_A511);

        // Zero-length advance is silent, 17 is an error
        cycle(1, 0, 16'h0, 0, 0, 0);
        cycle(0, 1, 16'h0F0F, 0, 0, 0);
        cycle(0, 1, 16'hF0F0, 0, 0, 0);
        cycle(0, 0, 16'h0, 1, 5'd0, 0);
        check("len0_err", 32'(err), 32'd0);
        check("len0_level", 32'(bit_level), 32'd32);
        cycle(0, 0, 16'h0, 1, 5'd17, 0);
        check("len17_err", 32'(err), 32'd1);
        check("len17_level", 32'(bit_level), 32'd32);
        check("len17_pos", bit_pos, 32'd0);

        // Fill to 48, collide advance with align, then reset mid-stream
        cycle(1, 0, 16'h0, 0, 0, 0);
        cycle(0, 1, 16'h1357, 0, 0, 0);
        cycle(0, 1, 16'h2468, 0, 0, 0);
        cycle(0, 1, 16'h9ACE, 0, 0, 0);
        check("full_level", 32'(bit_level), 32'd48);
        check("full_ready", 32'(in_ready), 32'd0);
        cycle(0, 1, 16'hFFFF, 0, 0, 0);
        check("full_drop", 32'(bit_level), 32'd48);
        cycle(0, 0, 16'h0, 1, 5'd5, 1);
        check("collide_err", 32'(err), 32'd1);
        check("collide_pos", bit_pos, 32'd5);
        cycle(1, 1, 16'hDEAD, 1, 5'd4, 1);
        check("midrst_level", 32'(bit_level), 32'd0);
        check("midrst_ready", 32'(in_ready), 32'd1);
        check("midrst_err", 32'(err), 32'd0);
        cycle(0, 1, 16'h8001, 0, 0, 0);
        check("midrst_first", 32'(win_data), 32'h0000_8001);

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            r_rst = ($urandom_range(0, 249) == 0);
            r_iv  = 1'($urandom_range(0, 1));
            r_d   = 16'($urandom);
            r_av  = ($urandom_range(0, 9) < 6) &&
                    (m_bits.size() >= 16 || $urandom_range(0, 39) == 0);
            if ($urandom_range(0, 59) == 0)      r_len = 5'($urandom_range(17, 31));
            else if ($urandom_range(0, 19) == 0) r_len = 5'd0;
            else                                 r_len = 5'($urandom_range(1, 16));
            r_al  = ($urandom_range(0, 5) == 0) && (!r_av || $urandom_range(0, 29) == 0);
            cycle(r_rst, r_iv, r_d, r_av, r_len, r_al);
        end

        cycle(0, 0, 16'h0, 0, 0, 0);
        @(posedge wb_clk_i);
        #2;
        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bs_window_buffer.md
BS_WINDOW_BUFFER -- requirements
Module: bs_window_buffer

Interface
REQ-001 SHALL declare parameter WORD_W, default 16, input word and window width in bits.
REQ-002 SHALL declare parameter BUF_W, default 48, internal bit-buffer capacity in bits (3 words).
REQ-003 SHALL declare ports as follows:
- wb_clk_i  in  1  sole clock, rising edge.
- wb_rst_i  in  1  synchronous, active-high reset.
- in_data  in  16  next bitstream word, MSB first in stream order.
- in_valid  in  1  in_data valid.
- in_ready  out  1  buffer can accept a word.
- win_data  out  16  next 16 unconsumed bits, MSB-aligned (bit 15 = next bit).
- win_valid  out  1  at least 16 unconsumed bits held.
- adv_valid  in  1  consume request.
- adv_len  in  5  bits to consume, legal range 1..16.
- align_req  in  1  skip to the next byte boundary of the stream.
- bit_level  out  6  unconsumed bits held, 0..48.
- bit_pos  out  32  total bits consumed since reset, mod 2^32.
- err  out  1  sticky protocol-error flag.

Function
REQ-004 SHALL hold unconsumed bits MSB-aligned in a BUF_W register; win_data SHALL be the buffer's top 16 bits.
REQ-005 SHALL drive win_data bits below bit_level as 0 when bit_level < 16.
REQ-006 SHALL assert in_ready when the registered bit_level <= 32, independent of same-cycle advances.
REQ-007 SHALL treat a push as in_valid && in_ready, appending in_data directly after the last unconsumed bit.
REQ-008 SHALL make a pushed word visible on win_data/bit_level one cycle after the push edge.
REQ-009 SHALL assert win_valid combinationally from registered bit_level >= 16.
REQ-010 SHALL treat an advance as adv_valid && win_valid && 1 <= adv_len <= 16.
- On advance: shift buffer left by adv_len, bit_level -= adv_len, bit_pos += adv_len.
- Result is visible the next cycle.
REQ-011 SHALL, when push and advance occur in the same cycle, apply both: new level = level - adv_len + 16, with new word placed after the remaining bits.
REQ-012 SHALL ignore adv_valid with adv_len = 0 (no state change, no error).
REQ-013 SHALL ignore adv_valid with adv_len > 16 or with win_valid = 0, and set err.
REQ-014 SHALL service align_req (when adv_valid = 0) as follows:
- Compute k = (8 - bit_pos[2:0]) mod 8.
- k = 0: no-op.
- k > 0 and bit_level >= k: consume k bits as in REQ-010.
- k > 0 and bit_level < k: ignore the request and set err.
REQ-015 SHALL, when align_req and adv_valid are both high, perform only the advance and set err.
REQ-016 SHALL let bit_pos wrap from 2^32-1 to 0 without flagging.
REQ-017 SHALL keep err set until reset; err SHALL NOT block further operation.

Reset
REQ-018 SHALL, on wb_clk_i edge with wb_rst_i high, clear the following, overriding any same-cycle push, advance or align:
- Buffer, bit_level, bit_pos and err to 0.
- win_valid to 0 and in_ready to 1.
REQ-019 SHALL discard all buffered bits on a reset mid-stream; the first post-reset push is stream bit 0.

Structure
REQ-020 SHALL take WORD_W, BUF_W, LVL_W = 6 and MAX_ADV = 16 from the shared package bs_pkg, which also holds the error-cause enum (ADV_EMPTY, ADV_RANGE, ALIGN_SHORT, ADV_ALIGN_COLLIDE).
REQ-021 SHALL implement shifting in one sub-module, bs_lshift48: a combinational 48-bit left shifter, shift 0..16.

Verification
REQ-022 SHALL cover: reset, then push 0xA5F0, 0x1234 -> cycle+1 win_data = 0xA5F0, bit_level = 32, win_valid = 1.
REQ-023 SHALL cover: from REQ-022 state, advance 4 -> win_data = 0x5F01, bit_level = 28, bit_pos = 4.
REQ-024 SHALL cover: bit_pos = 4, align_req -> consumes 4 bits, bit_pos = 8, win_data = 0xF012.
REQ-025 SHALL cover: bit_level = 32, push 0xBEEF with adv_len = 16 in the same cycle -> bit_level = 32; bits after the old window are followed by 0xBEEF.
REQ-026 SHALL cover, each in its own run, with err staying 1 afterwards:
- bit_level = 8, adv_valid with adv_len = 3 -> no state change, err = 1.
- adv_len = 17 -> no state change, err = 1.
REQ-027 SHALL cover: three pushes to reach bit_level = 48 -> in_ready = 0; then wb_rst_i mid-stream -> next cycle bit_level = 0, in_ready = 1, err = 0.
